clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set controller for the century clock. It drives the count-enable and per-field up/down adjust inputs of the cascaded digit counters. Raw push-buttons (mode, up, down) are synchronized and debounced here, then converted into single-cycle adjust pulses with hold-to-repeat. A RUN/SET state machine decides whether the counter chain free-runs from the timebase or is adjusted field by field.

## Interface
- N_FIELDS, 6, number of adjustable counter fields (index 0 = seconds, ascending to highest field)
- DEBOUNCE_CYCLES, 16, consecutive stable clk cycles required to accept a button level change (>=2)
- REPEAT_DELAY, 8, rep_tick_i pulses a held up/down must last before auto-repeat starts (>=1)
- REPEAT_RATE, 2, rep_tick_i pulses between auto-repeat pulses (>=1)
- TIMEOUT, 60, rep_tick_i pulses without any press event before SET auto-exits to RUN (>=1)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- tick_i  input  1  single-cycle timebase pulse (1 Hz), synchronous to clk
- rep_tick_i  input  1  single-cycle repeat/timeout timebase pulse, synchronous to clk
- btn_mode_i  input  1  raw mode button, asynchronous, active-high
- btn_up_i  input  1  raw up button, asynchronous, active-high
- btn_down_i  input  1  raw down button, asynchronous, active-high
- en_o  output  1  count enable to the lowest counter of the chain
- up_o  output  N_FIELDS  one-hot single-cycle increment pulse to the selected field
- down_o  output  N_FIELDS  one-hot single-cycle decrement pulse to the selected field
- sel_o  output  N_FIELDS  one-hot selected field in SET, all zero in RUN (display blink)
- setting_o  output  1  high while in SET

## Operation
- Each button: 2-flop synchronizer, then debouncer. The debounce counter increments each cycle the synchronized level differs from the debounced level and clears when they match. On reaching DEBOUNCE_CYCLES the debounced level toggles and the counter clears. Press events are rising edges of the debounced level, one cycle wide. Releases are debounced the same way.
- FSM states: RUN, SET.
- RUN: en_o = tick_i (combinational, same cycle). up_o, down_o, sel_o all 0. A mode press moves to SET with field index 0.
- SET: en_o = 0, and tick_i is ignored. A mode press advances the index by 1. A mode press at index N_FIELDS-1 returns to RUN. sel_o = one-hot(index).
- Adjust in SET:
  - An up press while debounced down is low emits up_o[index] for 1 cycle.
  - A down press while debounced up is low emits down_o[index] for 1 cycle.
  - If both debounced buttons are high, no pulses are emitted and the repeat counter is held at 0.
- Repeat: a rep counter counts rep_tick_i while exactly one of up/down is held.
  - At REPEAT_DELAY, one pulse is emitted.
  - After that, one pulse is emitted every REPEAT_RATE rep_ticks.
  - Releasing the button, a mode press, or leaving SET clears the repeat state.
- Priority within one cycle: mode press > up/down press > repeat pulse. A dropped up/down event is not queued.
- Timeout: an idle counter counts rep_tick_i in SET and clears on any press event (mode, up, down) or on any emitted repeat pulse. On reaching TIMEOUT, the FSM goes to RUN.
- Counter widths are clog2 of their maximum plus 1. No counter wraps: each saturates or clears as described above.
- Up/down pulses never occur in RUN. up_o and down_o are never both non-zero.

## Timing
- Reset: state RUN, index 0. All synchronizers, debounced levels and counters are 0. en_o follows tick_i immediately. up_o, down_o, sel_o and setting_o are 0.
- Reset asserted mid-SET or mid-repeat takes effect asynchronously. No pulse is emitted on reset release.
- Press latency: if a raw level change is first sampled at edge k, the debounced level changes at edge k+1+DEBOUNCE_CYCLES. up_o/down_o/sel_o/setting_o are registered and change at edge k+2+DEBOUNCE_CYCLES.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- sel_o and setting_o update on the same edge as the FSM state.
- The repeat pulse is registered one edge after the qualifying rep_tick_i cycle.
- A mode press on the same cycle as a timeout: the timeout wins and the FSM goes to RUN.

## Test plan
- Reset, then tick_i pulses every 10 cycles -> en_o mirrors tick_i, sel_o=0, setting_o=0, no up_o/down_o.
- Raw btn_up_i glitch of 5 cycles (DEBOUNCE_CYCLES=16) in SET -> no pulse. Held 40 cycles -> exactly one up_o[0] pulse at edge k+18.
- Mode pressed 6 times -> sel_o steps 000001..100000, then setting_o=0 and sel_o=0. en_o stays 0 throughout SET.
- In SET field 2, hold down for 14 rep_ticks (DELAY=8, RATE=2) -> down_o[2] pulses at press, then at rep_ticks 8, 10, 12 and 14: 5 pulses total.
- Both up and down held in SET -> no pulses. Mode and up pressed on the same cycle -> index advances and no up_o pulse.
- Enter SET, idle 60 rep_ticks -> auto return to RUN. Assert rst_n low mid-repeat -> all outputs 0 immediately.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the century clock: button conditioning, RUN/SET
// sequencing, per-field adjust pulses with hold-to-repeat and idle timeout.
//
// state | meaning
// RUN   | counter chain free-runs from tick_i, buttons other than mode ignored
// SET   | one field selected, up/down emit adjust pulses, tick_i ignored
module clock_set_ctrl #(
    parameter int N_FIELDS        = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 2,
    parameter int TIMEOUT         = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                rep_tick_i,
    input  logic                btn_mode_i,
    input  logic                btn_up_i,
    input  logic                btn_down_i,
    output logic                en_o,
    output logic [N_FIELDS-1:0] up_o,
    output logic [N_FIELDS-1:0] down_o,
    output logic [N_FIELDS-1:0] sel_o,
    output logic                setting_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam int TO_W    = $clog2(TIMEOUT) + 1;
    localparam int IDX_W   = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0]    DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]    RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_FIELDS - 1);
    localparam logic [N_FIELDS-1:0] ONE_HOT0   = N_FIELDS'(1);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

    // button vector order: [0] mode, [1] up, [2] down
    logic [2:0]            btn_raw;
    logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]            db_q, db_d, db_prev_q, db_prev_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            press;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic                  rep_arm_q, rep_arm_d;
    logic [TO_W-1:0]       idle_q, idle_d;
    logic [N_FIELDS-1:0]   up_q, up_d, down_q, down_d, sel_q, sel_d;
    logic                  setting_q, setting_d;
    logic                  held_one, timeout, rep_fire;

    assign btn_raw = {btn_down_i, btn_up_i, btn_mode_i};
    assign press   = db_q & ~db_prev_q;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        db_cnt_d  = db_cnt_q;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    db_d[b]     = ~db_q[b];
                    db_cnt_d[b] = '0;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end else begin
                db_cnt_d[b] = '0;
            end
        end
    end

    assign held_one = db_q[1] ^ db_q[2];
    assign timeout  = (state_q == SET) && rep_tick_i && (idle_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        idle_d    = idle_q;
        up_d      = '0;
        down_d    = '0;
        rep_fire  = 1'b0;

        if (state_q == RUN) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
            idle_d    = '0;
            if (press[0]) begin
                state_d = SET;
                idx_d   = '0;
            end
        end else begin
            // first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE ticks
            if (!held_one || press[0] || timeout) begin
                rep_cnt_d = '0;
                rep_arm_d = 1'b0;
            end else if (rep_tick_i) begin
                if ((!rep_arm_q && rep_cnt_q == DELAY_LAST) ||
                    ( rep_arm_q && rep_cnt_q == RATE_LAST)) begin
                    rep_fire  = 1'b1;
                    rep_cnt_d = '0;
                    rep_arm_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            if (timeout) begin
                state_d = RUN;
                idx_d   = '0;
            end else if (press[0]) begin
                if (idx_q == IDX_LAST) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (press[1] && !db_q[2]) begin
                up_d = ONE_HOT0 << idx_q;
            end else if (press[2] && !db_q[1]) begin
                down_d = ONE_HOT0 << idx_q;
            end else if (rep_fire) begin
                if (db_q[1]) up_d   = ONE_HOT0 << idx_q;
                else         down_d = ONE_HOT0 << idx_q;
            end

            if (timeout || (|press) || rep_fire) idle_d = '0;
            else if (rep_tick_i)                 idle_d = idle_q + TO_W'(1);
        end

        setting_d = (state_d == SET);
        sel_d     = (state_d == SET) ? (ONE_HOT0 << idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
            state_q   <= RUN;
            idx_q     <= '0;
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
            idle_q    <= '0;
            up_q      <= '0;
            down_q    <= '0;
            sel_q     <= '0;
            setting_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
            idle_q    <= idle_d;
            up_q      <= up_d;
            down_q    <= down_d;
            sel_q     <= sel_d;
            setting_q <= setting_d;
        end
    end

    assign en_o      = tick_i & (state_q == RUN);
    assign up_o      = up_q;
    assign down_o    = down_q;
    assign sel_o     = sel_q;
    assign setting_o = setting_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized
// field/direction/hold-length trials against an abstract pulse-count model.
module tb_clock_set_ctrl;

    localparam int NF = 6;
    localparam int DB = 16;
    localparam int RD = 8;
    localparam int RR = 2;
    localparam int TO = 60;
    localparam int SETTLE = DB + 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_i = 1'b0;
    logic          rep_tick_i = 1'b0;
    logic          btn_mode_i = 1'b0;
    logic          btn_up_i = 1'b0;
    logic          btn_down_i = 1'b0;
    logic          en_o;
    logic [NF-1:0] up_o, down_o, sel_o;
    logic          setting_o;

    clock_set_ctrl #(
        .N_FIELDS(NF), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .rep_tick_i(rep_tick_i),
        .btn_mode_i(btn_mode_i), .btn_up_i(btn_up_i), .btn_down_i(btn_down_i),
        .en_o(en_o), .up_o(up_o), .down_o(down_o), .sel_o(sel_o),
        .setting_o(setting_o)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc_n = 0;
    int up_seen [NF];
    int down_seen [NF];
    int tot_up, tot_down;
    int first_up;
    bit model_set = 1'b0;
    int model_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int f = 0; f < NF; f++) begin
            up_seen[f] = 0;
            down_seen[f] = 0;
        end
        tot_up = 0;
        tot_down = 0;
        first_up = -1;
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        for (int f = 0; f < NF; f++) begin
            if (up_o[f] === 1'b1) begin up_seen[f]++; tot_up++; end
            if (down_o[f] === 1'b1) begin down_seen[f]++; tot_down++; end
        end
        if ((|up_o) && first_up < 0) first_up = cyc_n;
        chk("up_down_exclusive", 32'((|up_o) && (|down_o)), 32'd0);
    endtask

    task automatic hold(input int n);
        repeat (n) cyc();
    endtask

    task automatic rep_pulse();
        rep_tick_i = 1'b1;
        cyc();
        rep_tick_i = 1'b0;
        hold(3);
    endtask

    function automatic logic [NF-1:0] exp_sel();
        logic [NF-1:0] one;
        one = NF'(1);
        return model_set ? (one << model_idx) : '0;
    endfunction

    function automatic int exp_pulses(input int n);
        return 1 + ((n >= RD) ? (1 + (n - RD) / RR) : 0);
    endfunction

    task automatic press_mode();
        btn_mode_i = 1'b1;
        hold(SETTLE);
        btn_mode_i = 1'b0;
        hold(SETTLE);
        if (!model_set) begin
            model_set = 1'b1;
            model_idx = 0;
        end else if (model_idx == NF - 1) begin
            model_set = 1'b0;
            model_idx = 0;
        end else begin
            model_idx++;
        end
        chk("mode_sel", 32'(sel_o), 32'(exp_sel()));
        chk("mode_setting", 32'(setting_o), 32'(model_set));
    endtask

    int f, dir, n, g, c0;

    initial begin
        clear_counts();
        hold(3);
        chk("rst_up", 32'(up_o), 32'd0);
        chk("rst_down", 32'(down_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_setting", 32'(setting_o), 32'd0);
        rst_n = 1'b1;
        hold(3);

        // RUN: en_o follows tick_i
        for (int i = 0; i < 5; i++) begin
            hold(10);
            tick_i = 1'b1;
            #1 chk("run_en_hi", 32'(en_o), 32'd1);
            cyc();
            tick_i = 1'b0;
            #1 chk("run_en_lo", 32'(en_o), 32'd0);
        end
        chk("run_no_pulses", 32'(tot_up + tot_down), 32'd0);
        chk("run_sel", 32'(sel_o), 32'd0);

        // enter SET, glitch then a real hold on up
        press_mode();
        clear_counts();
        btn_up_i = 1'b1;
        hold(5);
        btn_up_i = 1'b0;
        hold(SETTLE);
        chk("glitch_no_pulse", 32'(tot_up + tot_down), 32'd0);
        c0 = cyc_n;
        btn_up_i = 1'b1;
        hold(40);
        btn_up_i = 1'b0;
        hold(SETTLE);
        chk("hold_up_count", 32'(up_seen[0]), 32'd1);
        chk("hold_up_total", 32'(tot_up + tot_down), 32'd1);
        chk("hold_up_latency", 32'(first_up), 32'(c0 + 19));

        // step through every field and back to RUN; en_o blocked in SET
        for (int i = 1; i < NF; i++) begin
            press_mode();
            tick_i = 1'b1;
            #1 chk("set_en_blocked", 32'(en_o), 32'd0);
            cyc();
            tick_i = 1'b0;
        end
        press_mode();
        chk("exit_setting", 32'(setting_o), 32'd0);

        // field 2: hold down across 14 rep ticks
        press_mode(); press_mode(); press_mode();
        clear_counts();
        btn_down_i = 1'b1;
        hold(SETTLE);
        for (int i = 0; i < 14; i++) rep_pulse();
        btn_down_i = 1'b0;
        hold(SETTLE);
        chk("repeat14_field2", 32'(down_seen[2]), 32'(exp_pulses(14)));
        chk("repeat14_total", 32'(tot_up + tot_down), 32'd5);

        // both held: only the first up press emits
        clear_counts();
        btn_up_i = 1'b1;
        hold(SETTLE);
        btn_down_i = 1'b1;
        hold(SETTLE);
        for (int i = 0; i < 10; i++) rep_pulse();
        btn_down_i = 1'b0;
        hold(SETTLE);
        btn_up_i = 1'b0;
        hold(SETTLE);
        chk("both_up", 32'(up_seen[2]), 32'd1);
        chk("both_total", 32'(tot_up + tot_down), 32'd1);

        // mode and up on the same cycle: mode wins
        clear_counts();
        btn_mode_i = 1'b1;
        btn_up_i = 1'b1;
        hold(SETTLE);
        btn_mode_i = 1'b0;
        btn_up_i = 1'b0;
        hold(SETTLE);
        model_idx++;
        chk("mode_up_sel", 32'(sel_o), 32'(exp_sel()));
        chk("mode_up_no_pulse", 32'(tot_up + tot_down), 32'd0);

        // idle timeout boundary
        for (int i = 0; i < TO - 1; i++) rep_pulse();
        chk("timeout_minus1", 32'(setting_o), 32'd1);
        rep_pulse();
        model_set = 1'b0;
        model_idx = 0;
        chk("timeout_setting", 32'(setting_o), 32'd0);
        chk("timeout_sel", 32'(sel_o), 32'd0);

        // reset mid-repeat
        press_mode();
        clear_counts();
        btn_up_i = 1'b1;
        hold(SETTLE);
        for (int i = 0; i < 9; i++) rep_pulse();
        chk("pre_reset_pulses", 32'(up_seen[0]), 32'(exp_pulses(9)));
        rst_n = 1'b0;
        #1;
        chk("areset_up", 32'(up_o), 32'd0);
        chk("areset_down", 32'(down_o), 32'd0);
        chk("areset_sel", 32'(sel_o), 32'd0);
        chk("areset_setting", 32'(setting_o), 32'd0);
        chk("areset_en", 32'(en_o), 32'd0);
        model_set = 1'b0;
        model_idx = 0;
        hold(3);
        rst_n = 1'b1;
        clear_counts();
        hold(SETTLE + 5);
        btn_up_i = 1'b0;
        hold(SETTLE);
        chk("post_reset_no_pulse", 32'(tot_up + tot_down), 32'd0);
        chk("post_reset_setting", 32'(setting_o), 32'd0);

        // randomized field / direction / hold length trials
        for (int it = 0; it < 6; it++) begin
            f   = int'($urandom_range(0, NF - 1));
            dir = int'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 16));
            g   = int'($urandom_range(1, 12));
            press_mode();
            repeat (f) press_mode();
            clear_counts();
            if (dir == 1) btn_up_i = 1'b1; else btn_down_i = 1'b1;
            hold(g);
            btn_up_i = 1'b0;
            btn_down_i = 1'b0;
            hold(SETTLE);
            chk("rnd_glitch", 32'(tot_up + tot_down), 32'd0);
            if (dir == 1) btn_up_i = 1'b1; else btn_down_i = 1'b1;
            hold(SETTLE);
            for (int i = 0; i < n; i++) rep_pulse();
            btn_up_i = 1'b0;
            btn_down_i = 1'b0;
            hold(SETTLE);
            if (dir == 1) chk("rnd_field_up", 32'(up_seen[f]), 32'(exp_pulses(n)));
            else          chk("rnd_field_down", 32'(down_seen[f]), 32'(exp_pulses(n)));
            chk("rnd_total", 32'(tot_up + tot_down), 32'(exp_pulses(n)));
            repeat (NF - f) press_mode();
            chk("rnd_back_run", 32'(setting_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
